// File: rtl/intc_pkg.sv
// Shared types and default parameters for the interrupt controller.
// The FSM state encoding lives here so the bench and RTL agree on the names.
package intc_pkg;

    localparam int                INTC_NUM_IRQ_DEF    = 4;
    localparam int                INTC_ADDR_W_DEF     = 32;
    localparam logic [31:0]       INTC_VEC_BASE_DEF   = 32'h0000_0000;
    localparam int                INTC_VEC_STRIDE_DEF = 2;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        SERVICE = 2'd2
    } intc_state_e;

    // A single channel still needs a one-bit id port.
    function automatic int intc_id_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/intc_prio_enc.sv
// Combinational fixed-priority encoder: lowest set index wins.
module intc_prio_enc #(
    parameter int N    = 4,
    parameter int ID_W = 2
) (
    input  logic [N-1:0]    req_i,
    output logic            vld_o,
    output logic [ID_W-1:0] idx_o
);

    always_comb begin
        vld_o = |req_i;
        idx_o = '0;
        // Scan downwards so the lowest set index is the last one written.
        for (int i = N - 1; i >= 0; i--) begin
            if (req_i[i]) begin
                idx_o = ID_W'(i);
            end
        end
    end

endmodule

// File: rtl/interrupt_controller.sv
// Pending-latch interrupt controller with fixed-priority arbitration and an IDLE/REQ/SERVICE handshake.
// Requests are presented one at a time and held stable until acknowledged; no nesting.
module interrupt_controller
    import intc_pkg::*;
#(
    parameter int                NUM_IRQ    = INTC_NUM_IRQ_DEF,
    parameter int                ADDR_W     = INTC_ADDR_W_DEF,
    parameter logic [ADDR_W-1:0] VEC_BASE   = ADDR_W'(INTC_VEC_BASE_DEF),
    parameter int                VEC_STRIDE = INTC_VEC_STRIDE_DEF,
    localparam int               ID_W       = intc_id_width(NUM_IRQ)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_IRQ-1:0] irq_in,
    input  logic               cfg_we,
    input  logic [NUM_IRQ-1:0] cfg_mask,
    input  logic [NUM_IRQ-1:0] cfg_edge,
    input  logic               int_ack,
    input  logic               int_done,
    output logic               int_req,
    output logic [ID_W-1:0]    int_id,
    output logic [ADDR_W-1:0]  int_vector,
    output logic [NUM_IRQ-1:0] pending,
    output logic               busy
);

    intc_state_e        state_q;
    logic [NUM_IRQ-1:0] irq_q;
    logic [NUM_IRQ-1:0] mask_q;
    logic [NUM_IRQ-1:0] edge_q;
    logic [NUM_IRQ-1:0] pending_q;
    logic [NUM_IRQ-1:0] pending_d;
    logic [NUM_IRQ-1:0] set_vec;
    logic [NUM_IRQ-1:0] clr_vec;
    logic [NUM_IRQ-1:0] arb_req;
    logic               int_req_q;
    logic               busy_q;
    logic [ID_W-1:0]    int_id_q;
    logic [ADDR_W-1:0]  int_vector_q;
    logic [ADDR_W-1:0]  int_vector_d;
    logic               enc_vld;
    logic [ID_W-1:0]    enc_idx;

    // Deliberately not reset: a line held high through reset must not look like an edge afterwards.
    always_ff @(posedge clk) begin
        irq_q <= irq_in;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            mask_q <= '0;
            edge_q <= '1;
        end else if (cfg_we) begin
            mask_q <= cfg_mask;
            edge_q <= cfg_edge;
        end
    end

    always_comb begin
        set_vec = (edge_q & irq_in & ~irq_q) | (~edge_q & irq_in);
        clr_vec = '0;
        if (state_q == REQ && int_ack) begin
            clr_vec[int_id_q] = 1'b1;
        end
        // Set is OR-ed in after the clear so a re-assertion on the ack edge is not lost.
        pending_d = (pending_q & ~clr_vec) | set_vec;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pending_q <= '0;
        end else begin
            pending_q <= pending_d;
        end
    end

    assign arb_req = pending_q & mask_q;

    intc_prio_enc #(
        .N    (NUM_IRQ),
        .ID_W (ID_W)
    ) u_prio_enc (
        .req_i (arb_req),
        .vld_o (enc_vld),
        .idx_o (enc_idx)
    );

    assign int_vector_d = VEC_BASE + ADDR_W'(enc_idx) * ADDR_W'(VEC_STRIDE);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            int_req_q    <= 1'b0;
            int_id_q     <= '0;
            int_vector_q <= '0;
            busy_q       <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (enc_vld) begin
                        state_q      <= REQ;
                        int_req_q    <= 1'b1;
                        int_id_q     <= enc_idx;
                        int_vector_q <= int_vector_d;
                    end
                end
                REQ: begin
                    if (int_ack) begin
                        state_q   <= SERVICE;
                        int_req_q <= 1'b0;
                        busy_q    <= 1'b1;
                    end
                end
                SERVICE: begin
                    if (int_done) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q   <= IDLE;
                    int_req_q <= 1'b0;
                    busy_q    <= 1'b0;
                end
            endcase
        end
    end

    assign int_req    = int_req_q;
    assign int_id     = int_id_q;
    assign int_vector = int_vector_q;
    assign pending    = pending_q;
    assign busy       = busy_q;

endmodule
